univ_shift_reg: RTL
===================

# univ_shift_reg

Parametrised universal register that generalises the single-bit D flip-flop (d, q, q_bar) to a WIDTH-bit word with per-cycle operating modes: hold, logical/arithmetic shifts, rotates, parallel load and clear. A small burst sequencer repeats the selected operation a programmed number of cycles and reports busy/done. It is the storage and shift primitive for the serial and datapath blocks that follow in the design.

## Interface
Parameters:
- WIDTH, 8, register width in bits (>= 2)
- RESET_VAL, 0, value loaded into q on reset
- CW, $clog2(WIDTH+1), width of the burst count (derived, not overridden)

Ports:
- clk  input  1  rising-edge clock; the only clock
- reset  input  1  synchronous, active-high reset
- en  input  1  single-step enable, honoured in IDLE only
- mode  input  3  operation select (see Operation)
- d  input  WIDTH  parallel load data
- sin_r  input  1  serial in, enters bit 0 on left shift
- sin_l  input  1  serial in, enters bit WIDTH-1 on logical right shift
- start  input  1  burst request, honoured in IDLE only
- cnt  input  CW  burst length; values above WIDTH saturate to WIDTH
- q  output  WIDTH  registered state
- q_bar  output  WIDTH  ~q (combinational from q)
- sout_l  output  1  q[WIDTH-1]
- sout_r  output  1  q[0]
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse in DONE

## Operation
- Modes: 000 hold; 001 shift left, q <= {q[W-2:0], sin_r}; 010 logical shift right, q <= {sin_l, q[W-1:1]}; 011 arithmetic shift right, MSB replicated; 100 rotate left; 101 rotate right; 110 parallel load q <= d; 111 clear q <= 0.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 has priority over en. start with cnt=0 -> DONE, q unchanged. start with cnt>=1 -> latch mode into mode_r, apply the operation once at this edge, and set cnt_r = cnt-1. Then go to DONE if cnt==1, else to RUN. start=0, en=1 -> apply mode once, stay IDLE. Otherwise hold.
- RUN: apply mode_r each edge and decrement cnt_r. When cnt_r==1 at the edge, go to DONE. The mode, en and start inputs are ignored. sin_l, sin_r and d are sampled live every cycle.
- DONE: q holds; start/en ignored; next edge -> IDLE.
- A burst of N performs exactly N operations on N consecutive edges, starting with the start edge.
- Reset (any state): q <= RESET_VAL, state <= IDLE, cnt_r <= 0, mode_r <= 000. Reset overrides start/en on the same edge and aborts a burst with no further operations.

## Timing
- Reset values: q=RESET_VAL, q_bar=~RESET_VAL, sout_l/sout_r from RESET_VAL, busy=0, done=0.
- Single step: q reflects the operation one edge after en is sampled (latency 1).
- Burst N>=2: busy is high for N-1 cycles after the start edge. done is high for the 1 cycle after the last operation. The next start is accepted 2 cycles after the last operation edge.
- Burst N=1: busy never asserts; done is high in the cycle after the start edge.
- Burst N=0: done is high in the cycle after the start edge; q is unchanged.
- q_bar, sout_l and sout_r are purely combinational from q; no extra latency.
- There are no combinational paths from inputs to outputs.

## Test plan
All scenarios use WIDTH=8, RESET_VAL=0.
- Reset: assert reset 2 cycles with en=1, mode=110, d=0xFF -> q=0x00, q_bar=0xFF, busy=0, done=0.
- Single steps:
  - load 0xA5, then mode 001 with sin_r=1 -> q=0xA5 then 0x4B; sout_l=1 before the shift.
  - load 0x96, then mode 011 -> 0xCB.
  - then mode 010 with sin_l=0 -> 0x65.
- Burst rotate: load 0x81, start with mode=100, cnt=3 -> q=0x03, 0x06, 0x0C on successive edges; busy high 2 cycles; done pulses once; mode changed to 111 during RUN has no effect.
- Boundaries:
  - start with cnt=0 -> done next cycle, q unchanged.
  - start asserted during RUN is ignored.
  - cnt=15 saturates to 8: rotate of 0x5A returns 0x5A after 8 edges.
- Reset mid-burst: reset on the 2nd RUN cycle of a cnt=6 shift-left burst -> q=0x00, IDLE next cycle, done never pulses.
- Clear and hold: load 0x3C, mode 000 with en=1 for 4 cycles -> q stays 0x3C; then mode 111 -> 0x00, q_bar=0xFF.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: hold, shifts, rotates, load and clear, with a
// burst sequencer that repeats one operation a programmed number of cycles.
module univ_shift_reg #(
   parameter int unsigned          WIDTH     = 8,
   parameter logic [WIDTH-1:0]     RESET_VAL = '0,
   parameter int unsigned          CW        = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_r,
   input  logic             sin_l,
   input  logic             start,
   input  logic [CW-1:0]    cnt,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_bar,
   output logic             sout_l,
   output logic             sout_r,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   typedef enum logic [2:0] {
      OP_HOLD = 3'b000,
      OP_SHL  = 3'b001,
      OP_SHR  = 3'b010,
      OP_ASR  = 3'b011,
      OP_ROL  = 3'b100,
      OP_ROR  = 3'b101,
      OP_LOAD = 3'b110,
      OP_CLR  = 3'b111
   } op_t;

   localparam logic [CW-1:0] W_CNT = CW'(WIDTH);

   state_t          state;
   op_t             mode_r;
   logic [CW-1:0]   cnt_r;
   logic [CW-1:0]   cnt_sat;

   function automatic logic [WIDTH-1:0] apply_op(
      input op_t              op,
      input logic [WIDTH-1:0] cur,
      input logic [WIDTH-1:0] din,
      input logic             sr,
      input logic             sl
   );
      logic [WIDTH-1:0] nxt;
      nxt = cur;
      case (op)
         OP_HOLD: nxt = cur;
         OP_SHL:  nxt = {cur[WIDTH-2:0], sr};
         OP_SHR:  nxt = {sl, cur[WIDTH-1:1]};
         OP_ASR:  nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
         OP_ROL:  nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
         OP_ROR:  nxt = {cur[0], cur[WIDTH-1:1]};
         OP_LOAD: nxt = din;
         OP_CLR:  nxt = '0;
         default: nxt = cur;
      endcase
      return nxt;
   endfunction

   // Burst lengths beyond WIDTH are clamped so a full rotate is the longest burst.
   always_comb begin
      cnt_sat = (cnt > W_CNT) ? W_CNT : cnt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q      <= RESET_VAL;
         state  <= IDLE;
         cnt_r  <= '0;
         mode_r <= OP_HOLD;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (cnt_sat == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     // The start edge performs the first of the N operations.
                     q      <= apply_op(op_t'(mode), q, d, sin_r, sin_l);
                     mode_r <= op_t'(mode);
                     cnt_r  <= cnt_sat - CW'(1);
                     if (cnt_sat == CW'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                     end else begin
                        state <= RUN;
                        busy  <= 1'b1;
                     end
                  end
               end else if (en) begin
                  q <= apply_op(op_t'(mode), q, d, sin_r, sin_l);
               end
            end
            RUN: begin
               q     <= apply_op(mode_r, q, d, sin_r, sin_l);
               cnt_r <= cnt_r - CW'(1);
               if (cnt_r == CW'(1)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   assign q_bar  = ~q;
   assign sout_l = q[WIDTH-1];
   assign sout_r = q[0];

endmodule
